// File: rtl/qm_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : qm_muldiv
// Description : Iterative multiply/divide unit with architectural HI/LO.
//               MULT/MULTU use shift-add, DIV/DIVU use restoring division.
//               Every operation takes WIDTH CALC cycles plus one SIGN cycle.
// Ports       :
//   sys_clk, sys_rst_n   clock and asynchronous active-low reset
//   start, op, a, b      operation request (op: 00 MULT 01 MULTU 10 DIV 11 DIVU)
//   abort                cancels an in-flight operation without committing
//   hilo_rd              MFHI/MFLO in execute (only affects stall)
//   hi_we, lo_we, wdata  MTHI/MTLO writes, honoured only while idle
//   hi, lo               architectural HI/LO registers
//   busy, done, stall    status: in flight / result committed / hold pipe
// Revision    : 1.0  initial release
// ============================================================================
module qm_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             hilo_rd,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;      // mul: {hi_acc, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0]   opa;      // |a| or raw a: multiplicand / (loaded dividend)
  logic [WIDTH-1:0]   opb;      // |b| or raw b: divisor / (loaded multiplier)
  logic [WIDTH-1:0]   a_raw;    // raw dividend, returned in HI on divide by zero
  logic               is_div;
  logic               neg_q;    // product / quotient sign
  logic               neg_r;    // remainder sign
  logic               divzero;

  // Operand magnitudes at issue time
  logic               op_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // One iteration of each algorithm
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] div_next;

  // Sign-corrected results
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy  = (state != S_IDLE);
  assign stall = busy & (start | hilo_rd | hi_we | lo_we);

  always_comb begin
    op_signed = ~op[0];
    a_mag     = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag     = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  always_comb begin
    // Shift-add: (WIDTH+1)-bit sum keeps the carry, which shifts into the top.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opa};
    mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                      : {1'b0, acc[2*WIDTH-1:1]};

    // Restoring: the shifted remainder can need WIDTH+1 bits before the compare.
    // When it is >= divisor, the true difference fits in WIDTH bits.
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    rem_ge   = (rem_sh >= {1'b0, opb});
    rem_diff = rem_sh[WIDTH-1:0] - opb;
    div_next = rem_ge ? {rem_diff,          acc[WIDTH-2:0], 1'b1}
                      : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    prod_fix = neg_q ? (~acc + 1'b1) : acc;
    quot_fix = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opa     <= '0;
      opb     <= '0;
      a_raw   <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      divzero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // MT writes land even when start is also high; the result overwrites later.
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            opa     <= a_mag;
            opb     <= b_mag;
            a_raw   <= a;
            is_div  <= op[1];
            neg_q   <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r   <= op_signed & a[WIDTH-1];
            divzero <= op[1] & (b == '0);
            acc     <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            cnt     <= '0;
            state   <= S_CALC;
          end
        end

        S_CALC: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_ITER) state <= S_SIGN;
          end
        end

        S_SIGN: begin
          state <= S_IDLE;
          // A flush arriving on the commit cycle wins: nothing is written.
          if (!abort) begin
            done <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (divzero) begin
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
